// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with count-derived registered flags and sticky under/overrun.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data; default is a registered read.
module sync_fifo_param #(
  parameter int unsigned         DATA_WIDTH = 18,
  parameter int unsigned         ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH:0] UPAE       = '0,
  parameter logic [ADDR_WIDTH:0] UPAF       = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLUSH,
  input  logic                  WEN,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  REN,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  EMPTY,
  output logic                  EPO,
  output logic                  EWM,
  output logic                  UNDERRUN,
  output logic                  FULL,
  output logic                  FMO,
  output logic                  FWM,
  output logic                  OVERRUN
);

  localparam int unsigned         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_V  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] DEPTH_M1 = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] ONE_V    = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  clr;
  logic [ADDR_WIDTH:0]   count_nxt;

  // Written as count + UPAF >= DEPTH so the threshold cannot underflow.
  function automatic logic fwm_of(input logic [ADDR_WIDTH:0] v);
    return ({1'b0, v} + {1'b0, UPAF}) >= {1'b0, DEPTH_V};
  endfunction

  always_comb begin
    clr       = RST | FLUSH;
    wr_ok     = WEN & ~FULL;
    rd_ok     = REN & ~EMPTY;
    count_nxt = COUNT;
    if (wr_ok && !rd_ok) begin
      count_nxt = COUNT + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count_nxt = COUNT - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      COUNT    <= '0;
      EMPTY    <= 1'b1;
      EPO      <= 1'b0;
      EWM      <= 1'b1;
      FULL     <= 1'b0;
      FMO      <= 1'b0;
      FWM      <= fwm_of('0);
      UNDERRUN <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      COUNT <= count_nxt;
      EMPTY <= (count_nxt == '0);
      EPO   <= (count_nxt == ONE_V);
      EWM   <= (count_nxt <= UPAE);
      FULL  <= (count_nxt == DEPTH_V);
      FMO   <= (count_nxt == DEPTH_M1);
      FWM   <= fwm_of(count_nxt);
      if (REN && !rd_ok) UNDERRUN <= 1'b1;
      if (WEN && !wr_ok) OVERRUN  <= 1'b1;
    end
  end

  // Storage is never cleared; only pointers and count are reset.
  always_ff @(posedge CLK) begin
    if (!clr && wr_ok) begin
      mem[wr_ptr] <= WDATA;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign RDATA = EMPTY ? '0 : mem[rd_ptr];
`else
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge CLK) begin
    if (clr) begin
      rdata_q <= '0;
    end else if (rd_ok) begin
      rdata_q <= mem[rd_ptr];
    end
  end

  assign RDATA = rdata_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: queue reference model, decoupled monitor.
`timescale 1ns/1ps
module tb_sync_fifo_param;
  localparam int DW    = 18;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int UPAE  = 2;
  localparam int UPAF  = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          FLUSH = 1'b0;
  logic          WEN = 1'b0;
  logic          REN = 1'b0;
  logic [DW-1:0] WDATA = '0;
  logic [DW-1:0] RDATA;
  logic [AW:0]   COUNT;
  logic EMPTY, EPO, EWM, UNDERRUN, FULL, FMO, FWM, OVERRUN;

  sync_fifo_param #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .UPAE(5'(UPAE)),
    .UPAF(5'(UPAF))
  ) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .WEN(WEN), .WDATA(WDATA), .REN(REN),
    .RDATA(RDATA), .COUNT(COUNT),
    .EMPTY(EMPTY), .EPO(EPO), .EWM(EWM), .UNDERRUN(UNDERRUN),
    .FULL(FULL), .FMO(FMO), .FWM(FWM), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int            cnt;
    bit            und;
    bit            ovr;
    bit            rd_chk;
    logic [DW-1:0] rd;
  } exp_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] rd_q[$];
  exp_t          st_q[$];
  bit            m_und = 1'b0;
  bit            m_ovr = 1'b0;
  logic [DW-1:0] m_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle; the model advances on the same edge and queues its expectations.
  task automatic step(input bit rst, input bit flush, input bit wen,
                      input logic [DW-1:0] wd, input bit ren);
    exp_t e;
    bit   rd_acc;
    bit   wr_acc;
    RST = rst; FLUSH = flush; WEN = wen; WDATA = wd; REN = ren;
    @(posedge CLK);
    if (rst || flush) begin
      mq.delete();
      m_und = 1'b0;
      m_ovr = 1'b0;
      m_rdata = '0;
    end else begin
      rd_acc = ren && (mq.size() != 0);
      wr_acc = wen && (mq.size() != DEPTH);
      if (ren && !rd_acc) m_und = 1'b1;
      if (wen && !wr_acc) m_ovr = 1'b1;
      if (rd_acc) begin
        m_rdata = mq.pop_front();
        rd_q.push_back(m_rdata);
      end
      if (wr_acc) mq.push_back(wd);
    end
    e.cnt = mq.size();
    e.und = m_und;
    e.ovr = m_ovr;
`ifdef SYNC_FIFO_FWFT_EN
    e.rd_chk = (mq.size() != 0);
    e.rd     = (mq.size() != 0) ? mq[0] : '0;
`else
    e.rd_chk = 1'b1;
    e.rd     = m_rdata;
`endif
    st_q.push_back(e);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic reset_dut();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Monitor: DUT handshakes pull read words; every cycle pulls one state record.
  initial begin
    exp_t          e;
    logic [DW-1:0] w;
    bit            took;
`ifdef SYNC_FIFO_FWFT_EN
    logic [DW-1:0] rd_edge;
`endif
    forever begin
      @(posedge CLK);
      took = REN && !EMPTY && !RST && !FLUSH;
`ifdef SYNC_FIFO_FWFT_EN
      rd_edge = RDATA;
`endif
      @(negedge CLK);
      if (took) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_read", 32'd1, 32'd0);
        end else begin
          w = rd_q.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
          chk("rdata_stream", 32'(rd_edge), 32'(w));
`else
          chk("rdata_stream", 32'(RDATA), 32'(w));
`endif
        end
      end
      if (st_q.size() != 0) begin
        e = st_q.pop_front();
        chk("count",    32'(COUNT),    32'(e.cnt));
        chk("empty",    32'(EMPTY),    32'(e.cnt == 0));
        chk("epo",      32'(EPO),      32'(e.cnt == 1));
        chk("ewm",      32'(EWM),      32'(e.cnt <= UPAE));
        chk("full",     32'(FULL),     32'(e.cnt == DEPTH));
        chk("fmo",      32'(FMO),      32'(e.cnt == DEPTH - 1));
        chk("fwm",      32'(FWM),      32'(e.cnt >= DEPTH - UPAF));
        chk("underrun", 32'(UNDERRUN), 32'(e.und));
        chk("overrun",  32'(OVERRUN),  32'(e.ovr));
        if (e.rd_chk) chk("rdata_state", 32'(RDATA), 32'(e.rd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int pw, pr;
    bit fl, rs;

    reset_dut();
    reset_dut();
    @(negedge CLK);
    chk("reset_count", 32'(COUNT), 32'd0);
    chk("reset_empty", 32'(EMPTY), 32'd1);
    chk("reset_ewm",   32'(EWM),   32'd1);
    chk("reset_fwm",   32'(FWM),   32'd0);
    chk("reset_rdata", 32'(RDATA), 32'd0);

    // Fill, then one write too many.
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b0, 1'b1, DW'(i), 1'b0);
    @(negedge CLK);
    chk("fill_full",  32'(FULL),  32'd1);
    chk("fill_count", 32'(COUNT), 32'd16);
    step(1'b0, 1'b0, 1'b1, DW'(32'h11), 1'b0);
    @(negedge CLK);
    chk("fill17_count",   32'(COUNT),   32'd16);
    chk("fill17_overrun", 32'(OVERRUN), 32'd1);

    // Drain, then one read too many.
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge CLK);
    chk("drain_empty", 32'(EMPTY), 32'd1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge CLK);
    chk("drain17_underrun", 32'(UNDERRUN), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("drain17_rdata_hold", 32'(RDATA), 32'h10);
`endif

    // Simultaneous read/write at mid, empty and full.
    reset_dut();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, DW'(32'h100 + i), 1'b0);
    step(1'b0, 1'b0, 1'b1, DW'(32'h1FF), 1'b1);
    @(negedge CLK);
    chk("rw_mid_count", 32'(COUNT), 32'd8);
    reset_dut();
    step(1'b0, 1'b0, 1'b1, DW'(32'h155), 1'b1);
    @(negedge CLK);
    chk("rw_empty_count",    32'(COUNT),    32'd1);
    chk("rw_empty_underrun", 32'(UNDERRUN), 32'd1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b1, DW'(32'h180 + i), 1'b0);
    step(1'b0, 1'b0, 1'b1, DW'(32'h2AA), 1'b1);
    @(negedge CLK);
    chk("rw_full_count",   32'(COUNT),   32'd15);
    chk("rw_full_overrun", 32'(OVERRUN), 32'd1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Wrap-around with a one-word lag.
    reset_dut();
    step(1'b0, 1'b0, 1'b1, DW'(32'h20000), 1'b0);
    for (int i = 1; i < 40; i++) begin
      step(1'b0, 1'b0, 1'b1, DW'(32'h20000 + i), 1'b1);
      @(negedge CLK);
      chk("wrap_count_le1", 32'(COUNT <= 1), 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Flush at COUNT=5 with OVERRUN set, write in the same cycle.
    reset_dut();
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 1'b1, DW'(32'h300 + i), 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge CLK);
    chk("preflush_count",   32'(COUNT),   32'd5);
    chk("preflush_overrun", 32'(OVERRUN), 32'd1);
    step(1'b0, 1'b1, 1'b1, DW'(32'h3FFFF), 1'b0);
    @(negedge CLK);
    chk("flush_count",   32'(COUNT),   32'd0);
    chk("flush_empty",   32'(EMPTY),   32'd1);
    chk("flush_ewm",     32'(EWM),     32'd1);
    chk("flush_overrun", 32'(OVERRUN), 32'd0);
    idle();
    @(negedge CLK);
    chk("flush_write_dropped", 32'(COUNT), 32'd0);

    // Randomized traffic in write-heavy, read-heavy and balanced phases.
    for (int i = 0; i < 800; i++) begin
      case ((i / 100) % 4)
        0: begin pw = 80; pr = 25; end
        1: begin pw = 25; pr = 80; end
        2: begin pw = 55; pr = 55; end
        default: begin pw = 95; pr = 90; end
      endcase
      fl = ($urandom_range(0, 59) == 0);
      rs = ($urandom_range(0, 299) == 0);
      step(rs, fl, ($urandom_range(0, 99) < pw), DW'($urandom), ($urandom_range(0, 99) < pr));
    end

`ifdef SYNC_FIFO_FWFT_EN
    reset_dut();
    step(1'b0, 1'b0, 1'b1, DW'(32'h3ABCD), 1'b0);
    @(negedge CLK);
    chk("fwft_empty_low", 32'(EMPTY), 32'd0);
    chk("fwft_rdata",     32'(RDATA), 32'h3ABCD);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge CLK);
    chk("fwft_empty_after_read", 32'(EMPTY), 32'd1);
`endif

    idle();
    idle();
    @(negedge CLK);
    chk("reads_outstanding",  32'(rd_q.size()), 32'd0);
    chk("states_outstanding", 32'(st_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
